pll_lock_seq: RTL and testbench
===============================

# pll_lock_seq

PLL lock sequencer and core-reset generator. Runs on the free-running board reference clock and drives the PLL `rst` input. It supervises the PLL `locked` output (asynchronous to `clk`) and releases the core reset only after lock has been stable and a hold-off has elapsed. On lock loss it re-resets the PLL, retries on timeout, and latches a fault after repeated failures.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 16 — cycles `pll_rst` is held high per PLL reset pulse (≥1)
- `LOCK_TIMEOUT`, 65536 — max cycles from end of PLL reset to debounced lock (≥1)
- `DEBOUNCE_CYCLES`, 256 — consecutive cycles synchronized lock must stay high (≥1)
- `HOLDOFF_CYCLES`, 4096 — cycles between debounced lock and core reset release (≥1)
- `MAX_RETRY`, 3 — consecutive lock timeouts before FAULT (≥1)

Ports:
- `clk` in 1 — free-running reference clock (50 MHz)
- `rst_n` in 1 — synchronous, active-low reset
- `pll_locked` in 1 — PLL `locked`, asynchronous to `clk`
- `pll_rst` out 1 — PLL reset request, active high
- `core_rst_n` out 1 — core reset, active low; consumers re-synchronize it into their own domain
- `running` out 1 — high in RUN
- `fault` out 1 — high in FAULT
- `state` out 3 — RESET_PLL=0, WAIT_LOCK=1, DEBOUNCE=2, HOLDOFF=3, RUN=4, FAULT=5
- `lock_loss_cnt` out 8 — count of RUN→RESET_PLL transitions, saturates at 255

## Operation
- `pll_locked` passes through a 2-flop synchronizer (reset 0) to give `locked_s`.
- All outputs are registered and decoded from the state register. `pll_rst`=1 only in RESET_PLL and FAULT. `core_rst_n`=1 only in RUN.
- Reset (`rst_n`=0 at an edge) gives: state RESET_PLL, `pll_rst`=1, `core_rst_n`=0, `running`=0, `fault`=0, `lock_loss_cnt`=0, retry count 0, all timers 0. This applies in any state, including FAULT.
- **RESET_PLL:** count `PLL_RST_CYCLES` cycles, then go to WAIT_LOCK and clear the timeout timer.
- **WAIT_LOCK:** the timeout timer increments. `locked_s`=1 → DEBOUNCE with the debounce counter cleared.
- **DEBOUNCE:** the timeout timer keeps running (not cleared on bounce). The debounce counter increments while `locked_s`=1. `locked_s`=0 → WAIT_LOCK. After `DEBOUNCE_CYCLES` consecutive high cycles → HOLDOFF and clear the retry count.
- **Timeout:** the timer reaches `LOCK_TIMEOUT` in WAIT_LOCK or DEBOUNCE. Retry count increments. If the new count equals `MAX_RETRY` → FAULT, else → RESET_PLL.
- **HOLDOFF:** count `HOLDOFF_CYCLES`, then → RUN. `locked_s`=0 → RESET_PLL; this does not increment `lock_loss_cnt` or the retry count.
- **RUN:** `locked_s`=0 → RESET_PLL and increment `lock_loss_cnt` (saturating).
- **FAULT:** terminal; exit only via `rst_n`.
- **Simultaneous events:**
  - Debounce completion and timeout in the same cycle: debounce wins (→ HOLDOFF).
  - `locked_s` falling in the cycle HOLDOFF would complete: → RESET_PLL.
- Counter widths are sized by `$clog2(param+1)`. No counter wraps.

## Timing
- Let k be the first edge at which `pll_locked`=1 is captured by the first synchronizer flop.
  - `locked_s`=1 at k+1.
  - DEBOUNCE entered at k+2.
  - HOLDOFF entered at k+2+`DEBOUNCE_CYCLES`.
  - RUN entered, and `core_rst_n` rises, at k+2+`DEBOUNCE_CYCLES`+`HOLDOFF_CYCLES`.
- Lock loss in RUN: first flop captures 0 at edge m. At m+2, state is RESET_PLL, `core_rst_n`=0, `pll_rst`=1, and `lock_loss_cnt` is updated.
- After `rst_n` deasserts, `pll_rst` stays high for exactly `PLL_RST_CYCLES` cycles.
- Timeout fires exactly `LOCK_TIMEOUT` cycles after RESET_PLL exit when lock is never seen.

## Test plan
Bench parameters: `PLL_RST_CYCLES`=4, `LOCK_TIMEOUT`=100, `DEBOUNCE_CYCLES`=8, `HOLDOFF_CYCLES`=32, `MAX_RETRY`=3.
- **Clean lock:** release reset; raise `pll_locked` 20 cycles after `pll_rst` falls → `pll_rst` high 4 cycles; `core_rst_n` rises 42 cycles after the first capture edge; `running`=1; `lock_loss_cnt`=0.
- **Bounce:** `pll_locked` high 5 cycles, low 1, then high → returns to WAIT_LOCK, timer not cleared; RUN is reached 42 cycles after the final rise; no retry consumed.
- **Lock loss in RUN:** drop `pll_locked` → `core_rst_n`=0 and `pll_rst`=1 two edges after capture; `lock_loss_cnt`=1; relock reaches RUN again. Repeat 300 times → `lock_loss_cnt` holds at 255.
- **Retry/fault:** `pll_locked` stuck 0 → three 4-cycle `pll_rst` pulses, each 100 cycles apart after the pulse; then FAULT with `fault`=1, `pll_rst`=1, `state`=5. Later raising `pll_locked` has no effect.
- **Chattering lock:** lock high 7 cycles, low 1, repeated → timeout at 100 cycles counts as a retry.
- **Reset mid-operation:** assert `rst_n`=0 during HOLDOFF and again in FAULT → next edge `state`=0, `pll_rst`=1, `core_rst_n`=0, `fault`=0, `lock_loss_cnt`=0.

Source files
------------

// File: rtl/pll_lock_seq.sv
// PLL lock sequencer and core-reset generator.
// Holds the PLL in reset, waits for a debounced lock, applies a hold-off and
// then releases the core reset. Lock loss re-resets the PLL; repeated lock
// timeouts latch a terminal fault that only rst_n clears.
module pll_lock_seq #(
    parameter int PLL_RST_CYCLES  = 16,
    parameter int LOCK_TIMEOUT    = 65536,
    parameter int DEBOUNCE_CYCLES = 256,
    parameter int HOLDOFF_CYCLES  = 4096,
    parameter int MAX_RETRY       = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       core_rst_n,
    output logic       running,
    output logic       fault,
    output logic [2:0] state,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [2:0] S_RESET_PLL = 3'd0;
    localparam logic [2:0] S_WAIT_LOCK = 3'd1;
    localparam logic [2:0] S_DEBOUNCE  = 3'd2;
    localparam logic [2:0] S_HOLDOFF   = 3'd3;
    localparam logic [2:0] S_RUN       = 3'd4;
    localparam logic [2:0] S_FAULT     = 3'd5;

    localparam int RST_W = $clog2(PLL_RST_CYCLES + 1);
    localparam int TO_W  = $clog2(LOCK_TIMEOUT + 1);
    localparam int DB_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HO_W  = $clog2(HOLDOFF_CYCLES + 1);
    localparam int RTY_W = $clog2(MAX_RETRY + 1);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT - 1);
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HO_W-1:0]  HO_LAST  = HO_W'(HOLDOFF_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);

    logic             meta_q;
    logic             locked_s_q;

    logic [2:0]       state_q,   state_d;
    logic [RST_W-1:0] rst_cnt_q, rst_cnt_d;
    logic [TO_W-1:0]  to_cnt_q,  to_cnt_d;
    logic [DB_W-1:0]  db_cnt_q,  db_cnt_d;
    logic [HO_W-1:0]  ho_cnt_q,  ho_cnt_d;
    logic [RTY_W-1:0] retry_q,   retry_d;
    logic [7:0]       loss_q,    loss_d;

    logic             pll_rst_q;
    logic             core_rst_n_q;
    logic             running_q;
    logic             fault_q;
    logic             timeout;
    logic [RTY_W-1:0] retry_inc;

    // Two-flop synchronizer bringing the asynchronous PLL lock into clk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q     <= 1'b0;
            locked_s_q <= 1'b0;
        end else begin
            meta_q     <= pll_locked;
            locked_s_q <= meta_q;
        end
    end

    assign timeout   = (to_cnt_q == TO_LAST);
    assign retry_inc = retry_q + RTY_W'(1);

    // Next-state and counter logic for the lock sequence.
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        to_cnt_d  = to_cnt_q;
        db_cnt_d  = db_cnt_q;
        ho_cnt_d  = ho_cnt_q;
        retry_d   = retry_q;
        loss_d    = loss_q;
        case (state_q)
            S_RESET_PLL: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d  = S_WAIT_LOCK;
                    to_cnt_d = '0;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_W'(1);
                end
            end
            S_WAIT_LOCK: begin
                if (timeout) begin
                    retry_d   = retry_inc;
                    rst_cnt_d = '0;
                    state_d   = (retry_inc == RTY_MAX) ? S_FAULT : S_RESET_PLL;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (locked_s_q) begin
                        state_d  = S_DEBOUNCE;
                        db_cnt_d = '0;
                    end
                end
            end
            S_DEBOUNCE: begin
                // A completing debounce takes priority over a coincident timeout.
                if (locked_s_q && (db_cnt_q == DB_LAST)) begin
                    state_d  = S_HOLDOFF;
                    retry_d  = '0;
                    ho_cnt_d = '0;
                end else if (timeout) begin
                    retry_d   = retry_inc;
                    rst_cnt_d = '0;
                    state_d   = (retry_inc == RTY_MAX) ? S_FAULT : S_RESET_PLL;
                end else begin
                    // The timeout timer deliberately survives a bounce.
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (locked_s_q) begin
                        db_cnt_d = db_cnt_q + DB_W'(1);
                    end else begin
                        state_d = S_WAIT_LOCK;
                    end
                end
            end
            S_HOLDOFF: begin
                if (!locked_s_q) begin
                    state_d   = S_RESET_PLL;
                    rst_cnt_d = '0;
                end else if (ho_cnt_q == HO_LAST) begin
                    state_d = S_RUN;
                end else begin
                    ho_cnt_d = ho_cnt_q + HO_W'(1);
                end
            end
            S_RUN: begin
                if (!locked_s_q) begin
                    state_d   = S_RESET_PLL;
                    rst_cnt_d = '0;
                    if (loss_q != 8'hFF) begin
                        loss_d = loss_q + 8'd1;
                    end
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d   = S_RESET_PLL;
                rst_cnt_d = '0;
            end
        endcase
    end

    // State, counters and outputs; outputs decode the next state so they
    // change on the same edge as the state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RESET_PLL;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            db_cnt_q     <= '0;
            ho_cnt_q     <= '0;
            retry_q      <= '0;
            loss_q       <= '0;
            pll_rst_q    <= 1'b1;
            core_rst_n_q <= 1'b0;
            running_q    <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            db_cnt_q     <= db_cnt_d;
            ho_cnt_q     <= ho_cnt_d;
            retry_q      <= retry_d;
            loss_q       <= loss_d;
            pll_rst_q    <= (state_d == S_RESET_PLL) || (state_d == S_FAULT);
            core_rst_n_q <= (state_d == S_RUN);
            running_q    <= (state_d == S_RUN);
            fault_q      <= (state_d == S_FAULT);
        end
    end

    assign pll_rst       = pll_rst_q;
    assign core_rst_n    = core_rst_n_q;
    assign running       = running_q;
    assign fault         = fault_q;
    assign state         = state_q;
    assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_pll_lock_seq.sv
// Directed bench for pll_lock_seq with shortened timing parameters.
module tb_pll_lock_seq;

    logic       clk;
    logic       rst_n;
    logic       pll_locked;
    logic       pll_rst;
    logic       core_rst_n;
    logic       running;
    logic       fault;
    logic [2:0] state;
    logic [7:0] lock_loss_cnt;

    int checks   = 0;
    int failures = 0;
    int n;
    int exp_loss;
    bit chatter_en;
    int phase;

    localparam int P_PLLRST = 0;
    localparam int P_CORE   = 1;
    localparam int P_STATE  = 2;

    pll_lock_seq #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .DEBOUNCE_CYCLES(8),
        .HOLDOFF_CYCLES (32),
        .MAX_RETRY      (3)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .pll_rst      (pll_rst),
        .core_rst_n   (core_rst_n),
        .running      (running),
        .fault        (fault),
        .state        (state),
        .lock_loss_cnt(lock_loss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock edge, then drive the chatter pattern if enabled.
    task automatic step();
        @(posedge clk);
        #1;
        if (chatter_en) begin
            pll_locked = (phase != 7);
            phase      = (phase + 1) % 8;
        end
    endtask

    function automatic int probe(input int sel);
        case (sel)
            P_PLLRST: return int'(pll_rst);
            P_CORE:   return int'(core_rst_n);
            default:  return int'(state);
        endcase
    endfunction

    task automatic steps_until(input int sel, input int val, input int bound, output int cnt);
        cnt = 0;
        do begin
            step();
            cnt++;
        end while ((probe(sel) != val) && (cnt < bound));
    endtask

    initial begin
        rst_n      = 1'b0;
        pll_locked = 1'b0;
        chatter_en = 1'b0;
        phase      = 0;

        // Reset state
        step();
        chk("rst_state", state, 0);
        chk("rst_pll_rst", pll_rst, 1);
        chk("rst_core", core_rst_n, 0);
        chk("rst_fault", fault, 0);
        chk("rst_running", running, 0);
        chk("rst_loss", lock_loss_cnt, 0);
        rst_n = 1'b1;

        // Clean lock
        steps_until(P_PLLRST, 0, 50, n);
        chk("pll_rst_len", n, 4);
        repeat (20) step();
        chk("wait_state", state, 1);
        pll_locked = 1'b1;
        steps_until(P_CORE, 1, 200, n);
        chk("clean_lock_lat", n, 43);
        chk("clean_running", running, 1);
        chk("clean_state", state, 4);
        chk("clean_pll_rst", pll_rst, 0);
        chk("clean_loss", lock_loss_cnt, 0);

        // Lock loss in RUN
        pll_locked = 1'b0;
        step();
        step();
        chk("loss_core_early", core_rst_n, 1);
        step();
        chk("loss_core", core_rst_n, 0);
        chk("loss_pll_rst", pll_rst, 1);
        chk("loss_state", state, 0);
        chk("loss_cnt1", lock_loss_cnt, 1);
        pll_locked = 1'b1;
        steps_until(P_STATE, 4, 200, n);
        chk("relock_state", state, 4);

        // Repeated lock loss saturates the counter
        exp_loss = 1;
        for (int i = 0; i < 300; i++) begin
            pll_locked = 1'b0;
            repeat (3) step();
            pll_locked = 1'b1;
            steps_until(P_STATE, 4, 120, n);
            exp_loss = (exp_loss < 255) ? exp_loss + 1 : 255;
            if (i >= 250) chk("loss_loop", lock_loss_cnt, exp_loss);
        end
        chk("loss_sat", lock_loss_cnt, 255);

        // Reset during HOLDOFF
        pll_locked = 1'b0;
        repeat (3) step();
        pll_locked = 1'b1;
        steps_until(P_STATE, 3, 200, n);
        chk("holdoff_reached", state, 3);
        rst_n = 1'b0;
        step();
        chk("ho_rst_state", state, 0);
        chk("ho_rst_pll_rst", pll_rst, 1);
        chk("ho_rst_core", core_rst_n, 0);
        chk("ho_rst_fault", fault, 0);
        chk("ho_rst_loss", lock_loss_cnt, 0);
        rst_n      = 1'b1;
        pll_locked = 1'b0;

        // Bounce: high 5, low 1, then high
        steps_until(P_PLLRST, 0, 50, n);
        chk("bounce_pll_rst_len", n, 4);
        pll_locked = 1'b1;
        repeat (3) step();
        chk("bounce_debounce", state, 2);
        repeat (2) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        step();
        step();
        chk("bounce_back_wait", state, 1);
        step();
        chk("bounce_redebounce", state, 2);
        steps_until(P_STATE, 4, 200, n);
        chk("bounce_run_lat", n, 40);

        // Stuck-low lock: three PLL pulses then FAULT
        pll_locked = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        steps_until(P_PLLRST, 0, 50, n);
        chk("retry_pulse1", n, 4);
        steps_until(P_PLLRST, 1, 200, n);
        chk("retry_gap1", n, 100);
        chk("retry_state1", state, 0);
        steps_until(P_PLLRST, 0, 50, n);
        chk("retry_pulse2", n, 4);
        steps_until(P_PLLRST, 1, 200, n);
        chk("retry_gap2", n, 100);
        steps_until(P_PLLRST, 0, 50, n);
        chk("retry_pulse3", n, 4);
        steps_until(P_PLLRST, 1, 200, n);
        chk("retry_gap3", n, 100);
        chk("fault_state", state, 5);
        chk("fault_flag", fault, 1);
        chk("fault_pll_rst", pll_rst, 1);
        chk("fault_core", core_rst_n, 0);
        pll_locked = 1'b1;
        repeat (300) step();
        chk("fault_sticky_state", state, 5);
        chk("fault_sticky_flag", fault, 1);

        // Reset in FAULT
        rst_n = 1'b0;
        step();
        chk("flt_rst_state", state, 0);
        chk("flt_rst_pll_rst", pll_rst, 1);
        chk("flt_rst_core", core_rst_n, 0);
        chk("flt_rst_fault", fault, 0);
        chk("flt_rst_loss", lock_loss_cnt, 0);
        rst_n      = 1'b1;
        pll_locked = 1'b0;

        // Chattering lock counts as a retry on timeout
        steps_until(P_PLLRST, 0, 50, n);
        chk("chat_pll_rst_len", n, 4);
        pll_locked = 1'b1;
        phase      = 1;
        chatter_en = 1'b1;
        steps_until(P_PLLRST, 1, 200, n);
        chk("chat_timeout", n, 100);
        chatter_en = 1'b0;
        pll_locked = 1'b0;
        steps_until(P_STATE, 5, 400, n);
        chk("chat_fault_lat", n, 208);
        chk("chat_fault_flag", fault, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
